// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_rx_state_t;
`endif

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets the
// value both flops take in reset so an idle line does not look like an edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver using a 16x oversampling tick; samples each bit mid-period.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             rx,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             frame_err
);

  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  uart_rx_state_t   state;
  logic [3:0]       s;
  logic [NW-1:0]    n;
  logic [DBITS-1:0] b;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // rx_done_tick defaults low so it can only ever pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
      par_bit      <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s     <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s == 4'(UART_MID_TICK)) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s == 4'(UART_OVERSAMPLE - 1)) begin
              b <= {rx_s, b[DBITS-1:1]};
              s <= '0;
              if (n == NW'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s == 4'(UART_OVERSAMPLE - 1)) begin
              par_bit <= rx_s;
              s       <= '0;
              state   <= ST_STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          // A bad stop bit still completes the frame, flagged via frame_err.
          if (s_tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              rx_data      <= b;
              frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err   <= ^{b, par_bit};
`endif
              rx_done_tick <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Receive half of the UART: recovers serial frames (1 start, DBITS data LSB-first, optional parity, 1 stop) from the asynchronous `rx` line. Uses the 16× oversampling tick produced by the baud generator (one `s_tick` pulse every divisor period). Presents each received byte with a one-cycle done strobe to the downstream FIFO/consumer.

## Interface
- `DBITS`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks in the stop bit (16 = 1 stop bit).
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `s_tick`  input  1  one-clk oversampling enable, 16 per bit period.
- `rx`  input  1  asynchronous serial line, idle high.
- `rx_data`  output  DBITS  last received word, held until next done.
- `rx_done_tick`  output  1  one-clk pulse: `rx_data` valid.
- `frame_err`  output  1  stop bit sampled low; valid with `rx_done_tick`, held until next done.
- `parity_err`  output  1  only with `UART_RX_PARITY_EN`; same timing as `frame_err`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); the FSM uses only the synchronized `rx_s`.
- Counters: `s` (4 bits, tick count within a bit), `n` ($clog2(DBITS) bits, data-bit index), `b` (DBITS shift register).
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: on `rx_s`==0 -> START, `s`=0. Sampling needs no tick.
- START: each `s_tick` increments `s`. At `s_tick` with `s`==7: if `rx_s`==0 -> DATA, `s`=0, `n`=0; else -> IDLE (glitch rejection, no strobe).
- DATA: at `s_tick` with `s`==15: `b` <= {`rx_s`, `b`[DBITS-1:1]}, `s`=0; if `n`==DBITS-1 -> PARITY/STOP, else `n`++. Otherwise `s`++ on tick.
- PARITY: at `s_tick` with `s`==15: capture parity bit, `s`=0 -> STOP.
- STOP: at `s_tick` with `s`==SB_TICK-1: `rx_data`<=`b`, `frame_err`<=~`rx_s`, `rx_done_tick`<=1, -> IDLE. The frame completes even on a bad stop bit.
- `s_tick` absent: FSM holds state and counters.
- A new start edge is accepted in IDLE on the cycle after completion. Back-to-back frames with zero idle gap are supported.
- `s` wraps modulo 16 by construction; no other overflow is possible.

## Timing
- Reset (any state, including mid-frame): state IDLE, `s`=`n`=0, `b`=0, `rx_data`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, synchronizer=1. A partial frame is discarded silently.
- Input latency: 2 clk from `rx` pin to `rx_s`.
- `rx_done_tick` is registered. It is high exactly one clk, the cycle after the STOP-state `s_tick` with `s`==SB_TICK-1. `rx_data`, `frame_err` and `parity_err` update in that same cycle.
- Each data bit is sampled at tick 16·k+8 after the detected start edge, i.e. mid-bit (±1 tick detection jitter).

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state and `parity_err` port exist. Even parity: `parity_err` = ^{`b`, parity bit}, registered with `rx_done_tick`.
- Not defined: no PARITY state and no `parity_err` port. DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`: state enum `uart_rx_state_t`, `UART_OVERSAMPLE`=16, `UART_MID_TICK`=7. The package is reused by the transmitter.
- Sub-module `sync_2ff` (2-flop synchronizer, reset value parameter); the same module is used on other async inputs.

## Test plan
- `s_tick` every 4 clk, send 0xA5 with stop=1 -> `rx_data`=0xA5, one `rx_done_tick` pulse, `frame_err`=0.
- `rx` low for 5 ticks then high -> START aborts to IDLE, no `rx_done_tick`, `rx_data` unchanged.
- Send 0x3C with stop bit driven 0 -> `rx_done_tick`=1, `rx_data`=0x3C, `frame_err`=1. The next good frame 0x01 clears `frame_err` to 0.
- Frames 0x00 then 0xFF, no idle gap -> two pulses, data 0x00 then 0xFF, both `frame_err`=0.
- Assert `rst` one clk during data bit 4 of 0x55 -> all outputs 0, no strobe. A following frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `parity_err`=0; same data with parity bit 0 -> `parity_err`=1.
